// File: rtl/object_pkg.sv
// Shared definitions for the object sequencer and sprite renderer.
// This file holds the slot map, the Y_X word field positions and the draw-order step function.
package object_pkg;

    localparam int FIRST_ADDR = 2;
    localparam int LAST_ADDR  = 42;
    localparam int TOP_ADDR   = 32;
    localparam int HOLE_ADDR  = 24;

    localparam int ACTIVE_BIT = 31;
    localparam int FLIP_BIT   = 30;
    localparam int SPRITE_HI  = 28;
    localparam int SPRITE_LO  = 26;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RDWAIT,
        LAUNCH,
        WAIT_DONE,
        FINISH
    } seq_state_t;

    typedef struct packed {
        logic       last;
        logic [5:0] nxt;
    } slot_step_t;

    // Ascending walk skipping the hole and the player slot, then the player slot on top.
    function automatic slot_step_t next_slot(input logic [5:0] cur,
                                             input int last_addr = LAST_ADDR,
                                             input int top_addr  = TOP_ADDR,
                                             input int hole_addr = HOLE_ADDR);
        slot_step_t step;
        logic [5:0] n;
        step.last = (cur == 6'(top_addr));
        n = cur + 6'd1;
        for (int i = 0; i < 2; i++) begin
            if (n == 6'(hole_addr) || n == 6'(top_addr)) begin
                n = n + 6'd1;
            end
        end
        if (step.last || int'(n) > last_addr) begin
            n = 6'(top_addr);
        end
        step.nxt = n;
        return step;
    endfunction

endpackage

// File: rtl/object_sequencer.sv
// Per-frame object scheduler: walks the attribute RAM in draw order and launches the renderer
// once per active object, with a watchdog so a stuck renderer cannot stall the frame.
module object_sequencer
    import object_pkg::*;
#(
    parameter int WDOG_CYCLES = 2048,
    parameter int FIRST_ADDR  = object_pkg::FIRST_ADDR,
    parameter int LAST_ADDR   = object_pkg::LAST_ADDR,
    parameter int TOP_ADDR    = object_pkg::TOP_ADDR,
    parameter int HOLE_ADDR   = object_pkg::HOLE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [15:0] map_x_in,
    output logic [5:0]  mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    output logic [5:0]  obj_addr,
    output logic [31:0] obj_y_x,
    output logic        obj_start,
    input  logic        obj_done,
    output logic [15:0] map_x,
    output logic [7:0]  anim_clock,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        wdog_err
);

    localparam logic [10:0] WDOG_LAST = 11'(WDOG_CYCLES - 1);

    seq_state_t  state;
    logic [5:0]  cur;
    logic [10:0] wdog_cnt;
    slot_step_t  step;

    assign step = next_slot(cur, LAST_ADDR, TOP_ADDR, HOLE_ADDR);

    // Strobes are registered so mem_rd is high during FETCH, obj_start during LAUNCH
    // and frame_done during FINISH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            wdog_cnt   <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            obj_addr   <= '0;
            obj_y_x    <= '0;
            obj_start  <= 1'b0;
            map_x      <= '0;
            anim_clock <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            wdog_err   <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            obj_start  <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        map_x      <= map_x_in;
                        anim_clock <= anim_clock + 8'd1;
                        cur        <= 6'(FIRST_ADDR);
                        mem_addr   <= 6'(FIRST_ADDR);
                        mem_rd     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    state <= RDWAIT;
                end
                RDWAIT: begin
                    obj_y_x  <= mem_rdata;
                    obj_addr <= cur;
                    if (mem_rdata[ACTIVE_BIT]) begin
                        obj_start <= 1'b1;
                        state     <= LAUNCH;
                    end else if (step.last) begin
                        frame_done <= 1'b1;
                        state      <= FINISH;
                    end else begin
                        cur      <= step.nxt;
                        mem_addr <= step.nxt;
                        mem_rd   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                LAUNCH: begin
                    wdog_cnt <= '0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done arriving on the expiry cycle wins, so no error is flagged then.
                    if (obj_done || wdog_cnt == WDOG_LAST) begin
                        if (!obj_done) begin
                            wdog_err <= 1'b1;
                        end
                        if (step.last) begin
                            frame_done <= 1'b1;
                            state      <= FINISH;
                        end else begin
                            cur      <= step.nxt;
                            mem_addr <= step.nxt;
                            mem_rd   <= 1'b1;
                            state    <= FETCH;
                        end
                    end else begin
                        wdog_cnt <= wdog_cnt + 11'd1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_object_sequencer.sv
// Self-checking bench for object_sequencer: RAM and renderer models plus a draw-order
// reference built directly from the slot rules.
module tb_object_sequencer;
    import object_pkg::*;

    localparam int WDOG = 2048;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [15:0] map_x_in;
    logic [5:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic [5:0]  obj_addr;
    logic [31:0] obj_y_x;
    logic        obj_start;
    logic        obj_done;
    logic [15:0] map_x;
    logic [7:0]  anim_clock;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic        wdog_err;

    object_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .map_x_in   (map_x_in),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .obj_addr   (obj_addr),
        .obj_y_x    (obj_y_x),
        .obj_start  (obj_start),
        .obj_done   (obj_done),
        .map_x      (map_x),
        .anim_clock (anim_clock),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ram [0:63];
    int          lat [0:63];
    int          hang_slot = -1;
    int          rend_cnt;
    logic        prev_rd;
    logic [5:0]  fetch_q [$];
    logic [37:0] start_q [$];
    int          order [$];
    int          checks = 0;
    int          failures = 0;
    int          t0 = 0;
    int          exp_anim = 0;

    // Environment: 1-cycle-latency RAM, renderer with per-slot latency, and launch/fetch monitors.
    initial begin
        obj_done  = 1'b0;
        mem_rdata = '0;
        rend_cnt  = 0;
        prev_rd   = 1'b0;
        forever begin
            @(negedge clk);
            obj_done = 1'b0;
            if (reset) begin
                rend_cnt = 0;
            end else if (rend_cnt > 0) begin
                rend_cnt--;
                if (rend_cnt == 0) obj_done = 1'b1;
            end
            if (obj_start && !reset) begin
                start_q.push_back({obj_addr, obj_y_x});
                if (int'(obj_addr) != hang_slot) rend_cnt = lat[obj_addr];
            end
            if (mem_rd) begin
                fetch_q.push_back(mem_addr);
                mem_rdata = ram[mem_addr];
            end else if (!prev_rd) begin
                mem_rdata = $urandom;
            end
            prev_rd = mem_rd;
        end
    end

    task automatic checkOutput(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int frameLen();
        int n = 1;
        foreach (order[i]) begin
            if (ram[order[i]][ACTIVE_BIT]) n += 3 + ((order[i] == hang_slot) ? WDOG : lat[order[i]]);
            else n += 2;
        end
        return n;
    endfunction

    task automatic applyStimulus(input logic [15:0] mx);
        @(negedge clk);
        fetch_q.delete();
        start_q.delete();
        map_x_in    = mx;
        frame_start = 1'b1;
        t0          = cyc;
        exp_anim    = (exp_anim + 1) % 256;
        @(negedge clk);
        frame_start = 1'b0;
        checkOutput("busy_rise", busy, 1);
    endtask

    task automatic finishFrame();
        int          exp_len;
        logic [37:0] exp_starts [$];
        exp_len = frameLen();
        while (frame_done !== 1'b1 && (cyc - t0) < exp_len + 64) @(negedge clk);
        checkOutput("frame_len", cyc - t0, exp_len);
        checkOutput("anim_clock", anim_clock, exp_anim);
        @(negedge clk);
        checkOutput("idle_after", {busy, frame_done}, 0);
        foreach (order[i]) begin
            if (ram[order[i]][ACTIVE_BIT]) exp_starts.push_back({6'(order[i]), ram[order[i]]});
        end
        checkOutput("fetch_count", fetch_q.size(), order.size());
        for (int i = 0; i < order.size() && i < fetch_q.size(); i++)
            checkOutput("fetch_addr", fetch_q[i], order[i]);
        checkOutput("launch_count", start_q.size(), exp_starts.size());
        for (int i = 0; i < exp_starts.size() && i < start_q.size(); i++)
            checkOutput("launch_addr_yx", start_q[i], exp_starts[i]);
    endtask

    task automatic clearRam();
        for (int a = 0; a < 64; a++) begin
            ram[a] = {1'b0, 31'($urandom)};
            lat[a] = 10;
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        map_x_in    = '0;
        for (int a = FIRST_ADDR; a <= LAST_ADDR; a++)
            if (a != HOLE_ADDR && a != TOP_ADDR) order.push_back(a);
        order.push_back(TOP_ADDR);
        clearRam();
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {mem_addr, mem_rd, obj_addr, obj_y_x, obj_start, map_x,
                    anim_clock, busy, frame_done, overrun, wdog_err}, 0);
        reset = 1'b0;

        // All slots inactive: only fetches, 2 cycles per slot.
        applyStimulus(16'h1234);
        finishFrame();
        checkOutput("inactive_len", cyc - t0 - 1, 2 * 40 + 1);
        checkOutput("map_x_first", map_x, 16'h1234);

        // Player slot drawn last; scroll latched; overrun ignored mid-walk.
        clearRam();
        ram[5]  = $urandom | 32'h8000_0000;
        ram[32] = $urandom | 32'h8000_0000;
        ram[40] = $urandom | 32'h8000_0000;
        ram[40][FLIP_BIT] = 1'b1;
        ram[40][SPRITE_HI:SPRITE_LO] = 3'd5;
        applyStimulus(16'h0010);
        repeat (30) @(negedge clk);
        map_x_in = 16'h0020;
        checkOutput("overrun_pre", overrun, 0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        checkOutput("overrun_set", overrun, 1);
        checkOutput("map_x_held", map_x, 16'h0010);
        finishFrame();
        checkOutput("map_x_end", map_x, 16'h0010);

        // Randomised frames against the reference walk.
        for (int f = 0; f < 3; f++) begin
            logic [15:0] mx;
            for (int a = 0; a < 64; a++) begin
                ram[a] = $urandom;
                ram[a][ACTIVE_BIT] = ($urandom_range(0, 3) == 0);
                lat[a] = $urandom_range(1, 12);
            end
            mx = (f == 0) ? 16'h0020 : 16'($urandom);
            applyStimulus(mx);
            finishFrame();
            checkOutput("map_x_rand", map_x, mx);
        end

        // Done arriving on the watchdog expiry cycle counts as done.
        clearRam();
        ram[7] = $urandom | 32'h8000_0000;
        lat[7] = WDOG;
        applyStimulus(16'h0001);
        finishFrame();
        checkOutput("wdog_tie", wdog_err, 0);

        // Renderer never finishes slot 10: watchdog abandons it and slot 11 follows.
        clearRam();
        ram[10] = $urandom | 32'h8000_0000;
        ram[11] = $urandom | 32'h8000_0000;
        lat[11] = 5;
        hang_slot = 10;
        applyStimulus(16'h0002);
        finishFrame();
        checkOutput("wdog_err", wdog_err, 1);
        hang_slot = -1;

        // Reset while waiting on the renderer.
        clearRam();
        ram[5] = $urandom | 32'h8000_0000;
        lat[5] = 40;
        applyStimulus(16'h0003);
        for (int k = 0; k < 60 && start_q.size() == 0; k++) @(negedge clk);
        checkOutput("reset_launch_seen", start_q.size(), 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_midframe", {mem_addr, mem_rd, obj_addr, obj_y_x, obj_start, map_x,
                    anim_clock, busy, frame_done, overrun, wdog_err}, 0);
        @(negedge clk);
        reset    = 1'b0;
        exp_anim = 0;
        applyStimulus(16'h0004);
        finishFrame();

        // Animation clock wraps after 256 accepted frames.
        clearRam();
        for (int f = 0; f < 255; f++) begin
            applyStimulus(16'h0000);
            while (frame_done !== 1'b1 && (cyc - t0) < 200) @(negedge clk);
            checkOutput("quick_len", cyc - t0, 81);
            @(negedge clk);
            if (f == 253) checkOutput("anim_255", anim_clock, 255);
        end
        checkOutput("anim_wrap", anim_clock, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
